// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the T flip-flop counter controller.
// Imported by the controller and by anything that decodes its state.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_counter_ctrl_if.sv
// Command and status bundle between the issuing control logic (master)
// and the counter controller (slave).
interface tff_counter_ctrl_if #(
    parameter int WIDTH = 4
);

    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_vec;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, pause, dir,
        input  count, t_vec, tc, busy, done
    );

    modport slave (
        input  start, stop, pause, dir,
        output count, t_vec, tc, busy, done
    );

endinterface

// File: rtl/tff_cell.sv
// Single synchronous T flip-flop: toggles on the rising edge while t is high.
module tff_cell (
    input  logic En,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge En) begin
        if (reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Modulo-N up/down counter built from a bank of T cells; a small FSM decides
// the next count and the cells only ever see count XOR next_count.
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter bit ONE_SHOT = 1'b0
) (
    input logic             En,
    input logic             reset,
    tff_counter_ctrl_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] start_val;

    always_ff @(posedge En) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign terminal  = (bus.dir == DIR_UP)   ? MAX_VAL : '0;
    assign start_val = (bus.dir == DIR_DOWN) ? MAX_VAL : '0;

    // Command priority is stop > start > pause > count; reset is handled in the registers.
    always_comb begin
        next_state = state;
        next_count = count;
        if (bus.stop) begin
            next_state = IDLE;
            next_count = '0;
        end else if (bus.start) begin
            next_state = RUN;
            next_count = start_val;
        end else begin
            case (state)
                IDLE: begin
                    next_count = '0;
                end
                RUN: begin
                    if (bus.pause) begin
                        next_state = HOLD;
                    end else if (ONE_SHOT && (count == terminal)) begin
                        next_state = DONE;
                    end else if ({1'b0, count} >= MOD_EXT) begin
                        next_count = '0;
                    end else if (bus.dir == DIR_UP) begin
                        next_count = (count == MAX_VAL) ? '0 : count + WIDTH'(1);
                    end else begin
                        next_count = (count == '0) ? MAX_VAL : count - WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (!bus.pause) begin
                        next_state = RUN;
                    end
                end
                DONE: begin
                    next_state = DONE;
                end
                default: begin
                    next_state = IDLE;
                    next_count = '0;
                end
            endcase
        end
    end

    assign t_vec = count ^ next_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .En    (En),
            .reset (reset),
            .t     (t_vec[i]),
            .q     (count[i])
        );
    end

    assign bus.count = count;
    assign bus.t_vec = t_vec;
    assign bus.tc    = (state == RUN) && (count == terminal);
    assign bus.busy  = (state == RUN) || (state == HOLD);
    assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed bench for tff_counter_ctrl: a free-running instance driven from a
// vector table and a one-shot instance driven by a hand-written sequence.
module tb_tff_counter_ctrl;

    logic En = 1'b0;
    logic reset;

    always #5 En = ~En;

    tff_counter_ctrl_if #(.WIDTH(4)) bus0 ();
    tff_counter_ctrl_if #(.WIDTH(4)) bus1 ();

    tff_counter_ctrl #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1'b0)) dut0 (
        .En    (En),
        .reset (reset),
        .bus   (bus0)
    );

    tff_counter_ctrl #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1'b1)) dut1 (
        .En    (En),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       pause;
        logic       dir;
        logic [3:0] exp_count;
        logic       exp_tc;
        logic       exp_busy;
        logic       chk_t;
        logic [3:0] exp_tvec;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic r, input logic s, input logic st, input logic p, input logic d,
                          input logic [3:0] c, input logic tc, input logic b,
                          input logic ck, input logic [3:0] tv);
        vec_t v;
        v.rst = r; v.start = s; v.stop = st; v.pause = p; v.dir = d;
        v.exp_count = c; v.exp_tc = tc; v.exp_busy = b; v.chk_t = ck; v.exp_tvec = tv;
        vecs.push_back(v);
    endtask

    // t_vec is checked before the edge it drives; count/tc/busy/done after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge En);
        reset      = v.rst;
        bus0.start = v.start;
        bus0.stop  = v.stop;
        bus0.pause = v.pause;
        bus0.dir   = v.dir;
        #1;
        if (v.chk_t) checkOutput($sformatf("v%0d.t_vec", idx), {4'b0, bus0.t_vec}, {4'b0, v.exp_tvec});
        @(posedge En);
        #1;
        checkOutput($sformatf("v%0d.count", idx), {4'b0, bus0.count}, {4'b0, v.exp_count});
        checkOutput($sformatf("v%0d.tc", idx),    {7'b0, bus0.tc},     {7'b0, v.exp_tc});
        checkOutput($sformatf("v%0d.busy", idx),  {7'b0, bus0.busy},   {7'b0, v.exp_busy});
        checkOutput($sformatf("v%0d.done", idx),  {7'b0, bus0.done},   8'd0);
    endtask

    task automatic stepOneShot(input logic s, input logic st, input logic p, input logic d);
        @(negedge En);
        reset      = 1'b0;
        bus1.start = s;
        bus1.stop  = st;
        bus1.pause = p;
        bus1.dir   = d;
        @(posedge En);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus0.start = 1'b0; bus0.stop = 1'b0; bus0.pause = 1'b0; bus0.dir = 1'b0;
        bus1.start = 1'b0; bus1.stop = 1'b0; bus1.pause = 1'b0; bus1.dir = 1'b0;

        //     rst st  sp  pa  dir  count tc  busy chk tvec
        addVec(1, 1, 0, 0, 0, 4'd0, 0, 0, 0, 4'b0000);
        addVec(1, 1, 0, 0, 0, 4'd0, 0, 0, 0, 4'b0000);
        addVec(0, 1, 0, 0, 0, 4'd0, 0, 1, 1, 4'b0000);
        addVec(0, 0, 0, 0, 0, 4'd1, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd2, 0, 1, 1, 4'b0011);
        addVec(0, 0, 0, 0, 0, 4'd3, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd4, 0, 1, 1, 4'b0111);
        addVec(0, 0, 0, 0, 0, 4'd5, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd6, 0, 1, 1, 4'b0011);
        addVec(0, 0, 0, 0, 0, 4'd7, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd8, 0, 1, 1, 4'b1111);
        addVec(0, 0, 0, 0, 0, 4'd9, 1, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd0, 0, 1, 1, 4'b1001);
        addVec(0, 0, 0, 0, 0, 4'd1, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd2, 0, 1, 1, 4'b0011);
        addVec(0, 0, 0, 0, 0, 4'd3, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd4, 0, 1, 1, 4'b0111);
        addVec(0, 0, 0, 0, 0, 4'd5, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 1, 0, 4'd5, 0, 1, 1, 4'b0000);
        addVec(0, 0, 0, 1, 0, 4'd5, 0, 1, 1, 4'b0000);
        addVec(0, 0, 0, 1, 0, 4'd5, 0, 1, 1, 4'b0000);
        addVec(0, 0, 0, 0, 0, 4'd5, 0, 1, 1, 4'b0000);
        addVec(0, 0, 0, 0, 0, 4'd6, 0, 1, 1, 4'b0011);
        addVec(0, 0, 0, 0, 0, 4'd7, 0, 1, 1, 4'b0001);
        addVec(0, 0, 1, 0, 0, 4'd0, 0, 0, 1, 4'b0111);
        addVec(0, 1, 1, 0, 0, 4'd0, 0, 0, 1, 4'b0000);
        addVec(0, 1, 0, 0, 1, 4'd9, 0, 1, 1, 4'b1001);
        addVec(0, 0, 0, 0, 1, 4'd8, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 1, 4'd7, 0, 1, 1, 4'b1111);
        addVec(0, 0, 0, 0, 1, 4'd6, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 1, 4'd5, 0, 1, 1, 4'b0011);
        addVec(0, 0, 0, 0, 1, 4'd4, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 1, 4'd3, 0, 1, 1, 4'b0111);
        addVec(0, 0, 0, 0, 1, 4'd2, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 1, 4'd1, 0, 1, 1, 4'b0011);
        addVec(0, 0, 0, 0, 1, 4'd0, 1, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 1, 4'd9, 0, 1, 1, 4'b1001);
        addVec(0, 0, 0, 0, 1, 4'd8, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 1, 4'd7, 0, 1, 1, 4'b1111);
        addVec(0, 0, 0, 0, 1, 4'd6, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 1, 4'd5, 0, 1, 1, 4'b0011);
        addVec(0, 0, 0, 0, 1, 4'd4, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd5, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd6, 0, 1, 1, 4'b0011);
        addVec(0, 1, 0, 1, 0, 4'd0, 0, 1, 1, 4'b0110);
        addVec(0, 0, 0, 1, 0, 4'd0, 0, 1, 1, 4'b0000);
        addVec(0, 0, 0, 0, 0, 4'd0, 0, 1, 1, 4'b0000);
        addVec(0, 0, 0, 0, 0, 4'd1, 0, 1, 1, 4'b0001);
        addVec(0, 0, 0, 0, 0, 4'd2, 0, 1, 1, 4'b0011);
        addVec(0, 0, 0, 0, 0, 4'd3, 0, 1, 1, 4'b0001);
        addVec(1, 1, 0, 0, 0, 4'd0, 0, 0, 0, 4'b0000);

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // One-shot: count up to 9, park in DONE, then restart.
        stepOneShot(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("os.start.count", {4'b0, bus1.count}, 8'd0);
        checkOutput("os.start.busy",  {7'b0, bus1.busy},  8'd1);
        for (int i = 1; i <= 9; i++) begin
            stepOneShot(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("os.run%0d.count", i), {4'b0, bus1.count}, 8'(i));
            checkOutput($sformatf("os.run%0d.tc", i),    {7'b0, bus1.tc},    (i == 9) ? 8'd1 : 8'd0);
            checkOutput($sformatf("os.run%0d.done", i),  {7'b0, bus1.done},  8'd0);
        end
        for (int k = 0; k < 6; k++) begin
            stepOneShot(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("os.hold%0d.count", k), {4'b0, bus1.count}, 8'd9);
            checkOutput($sformatf("os.hold%0d.done", k),  {7'b0, bus1.done},  8'd1);
            checkOutput($sformatf("os.hold%0d.busy", k),  {7'b0, bus1.busy},  8'd0);
            checkOutput($sformatf("os.hold%0d.t_vec", k), {4'b0, bus1.t_vec}, 8'd0);
        end
        stepOneShot(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("os.restart.count", {4'b0, bus1.count}, 8'd0);
        checkOutput("os.restart.busy",  {7'b0, bus1.busy},  8'd1);
        checkOutput("os.restart.done",  {7'b0, bus1.done},  8'd0);
        stepOneShot(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("os.restart1.count", {4'b0, bus1.count}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
